// File: rtl/id_stage_if.sv
// -----------------------------------------------------------------------------
// id_stage_if
// Purpose : Bundles every non-clock/reset signal of the RV32I decode stage:
//           the IF/ID instruction, the register-file read port, the WB write
//           port snoop, the EX control inputs and the ID/EX register outputs.
// Modports:
//   slave  - the decode stage itself (consumes IF/ID, RF, WB and EX control;
//            drives RF read indices, stall_if and the ID/EX register)
//   master - the surrounding pipeline (drives IF/ID, RF data, WB, flush,
//            ex_hold; observes the ID/EX register)
// Signals :
//   id_valid, id_inst, id_pc                 IF/ID register contents
//   rs1_index, rs2_index                     RF read indices
//   rf_data1, rf_data2                       RF combinational read data
//   wb_w_en, wb_w_index, wb_w_data           WB write port (bypass source)
//   flush, ex_hold                           redirect kill / downstream stall
//   stall_if                                 hold PC and IF/ID this cycle
//   ex_*                                     ID/EX pipeline register
// -----------------------------------------------------------------------------
interface id_stage_if #(
   parameter int XLEN = 32
);
   logic            id_valid;
   logic [31:0]     id_inst;
   logic [XLEN-1:0] id_pc;
   logic [4:0]      rs1_index;
   logic [4:0]      rs2_index;
   logic [XLEN-1:0] rf_data1;
   logic [XLEN-1:0] rf_data2;
   logic            wb_w_en;
   logic [4:0]      wb_w_index;
   logic [XLEN-1:0] wb_w_data;
   logic            flush;
   logic            ex_hold;
   logic            stall_if;
   logic            ex_valid;
   logic [XLEN-1:0] ex_pc;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [4:0]      ex_rd;
   logic [6:0]      ex_opcode;
   logic [2:0]      ex_funct3;
   logic            ex_funct7b5;
   logic            ex_reg_write;
   logic            ex_is_load;

   modport slave (
      input  id_valid, id_inst, id_pc,
      input  rf_data1, rf_data2,
      input  wb_w_en, wb_w_index, wb_w_data,
      input  flush, ex_hold,
      output rs1_index, rs2_index, stall_if,
      output ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
      output ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
      output ex_reg_write, ex_is_load
   );

   modport master (
      output id_valid, id_inst, id_pc,
      output rf_data1, rf_data2,
      output wb_w_en, wb_w_index, wb_w_data,
      output flush, ex_hold,
      input  rs1_index, rs2_index, stall_if,
      input  ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm,
      input  ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_funct3, ex_funct7b5,
      input  ex_reg_write, ex_is_load
   );
endinterface

// File: rtl/id_stage.sv
// -----------------------------------------------------------------------------
// id_stage
// Purpose : RV32I decode stage between the IF/ID register and EX. Drives the
//           register-file read indices, bypasses same-cycle writeback data,
//           generates the immediate, detects load-use hazards and holds the
//           ID/EX pipeline register with flush / hold / bubble control.
// Parameters:
//   XLEN      datapath width (only 32 supported)
//   BYPASS_EN 1 = WB-to-ID bypass, 0 = raw register-file data
// Ports:
//   clk  clock, all state on the rising edge
//   rst  synchronous active-high reset
//   bus  id_stage_if.slave, see the interface header for the signal list
// -----------------------------------------------------------------------------
module id_stage #(
   parameter int XLEN      = 32,
   parameter bit BYPASS_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   id_stage_if.slave   bus
);

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic            funct7b5;
      logic            reg_write;
      logic            is_load;
   } ex_reg_t;

   // Instruction field slices
   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [2:0]      w_funct3;
   logic [31:0]     w_inst;

   // Decode results
   logic            w_uses_rs1;
   logic            w_uses_rs2;
   logic            w_writes_rd;
   logic            w_is_load;
   logic [XLEN-1:0] w_imm;
   logic            w_byp1;
   logic            w_byp2;
   logic [XLEN-1:0] w_op1;
   logic [XLEN-1:0] w_op2;
   logic            w_load_use;
   ex_reg_t         w_next;

   ex_reg_t         r_ex;

   assign w_inst   = bus.id_inst;
   assign w_opcode = w_inst[6:0];
   assign w_rd     = w_inst[11:7];
   assign w_funct3 = w_inst[14:12];
   assign w_rs1    = w_inst[19:15];
   assign w_rs2    = w_inst[24:20];

   // Read indices are raw slices so the register file can start its read
   // regardless of whether the IF/ID slot holds a valid instruction.
   assign bus.rs1_index = w_rs1;
   assign bus.rs2_index = w_rs2;

   // -------------------------------------------------------------------------
   // Opcode classification and immediate generation
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default before the
      // case so that an unlisted opcode cannot leave a path that infers a latch.
      w_uses_rs1  = 1'b1;
      w_uses_rs2  = 1'b0;
      w_writes_rd = 1'b0;
      w_is_load   = 1'b0;
      w_imm       = '0;
      unique case (w_opcode)
         OP_LUI, OP_AUIPC: begin
            w_uses_rs1  = 1'b0;
            w_writes_rd = 1'b1;
            w_imm       = {w_inst[31:12], 12'b0};
         end
         OP_JAL: begin
            w_uses_rs1  = 1'b0;
            w_writes_rd = 1'b1;
            w_imm       = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20],
                           w_inst[30:21], 1'b0};
         end
         OP_JALR, OP_IMM: begin
            w_writes_rd = 1'b1;
            w_imm       = {{20{w_inst[31]}}, w_inst[31:20]};
         end
         OP_LOAD: begin
            w_writes_rd = 1'b1;
            w_is_load   = 1'b1;
            w_imm       = {{20{w_inst[31]}}, w_inst[31:20]};
         end
         OP_STORE: begin
            w_uses_rs2  = 1'b1;
            w_imm       = {{20{w_inst[31]}}, w_inst[31:25], w_inst[11:7]};
         end
         OP_BRANCH: begin
            w_uses_rs2  = 1'b1;
            w_imm       = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25],
                           w_inst[11:8], 1'b0};
         end
         OP_REG: begin
            w_uses_rs2  = 1'b1;
            w_writes_rd = 1'b1;
         end
         default: begin
            // Unknown opcode: still reads rs1 for hazard purposes, but never
            // writes, never loads and carries a zero immediate.
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // WB-to-ID bypass: the register file only shows a write after the edge,
   // so a same-cycle writeback to a source register must be forwarded here.
   // x0 is hard-wired and is never bypassed.
   // -------------------------------------------------------------------------
   assign w_byp1 = BYPASS_EN && bus.wb_w_en && (bus.wb_w_index != 5'd0)
                   && (bus.wb_w_index == w_rs1);
   assign w_byp2 = BYPASS_EN && bus.wb_w_en && (bus.wb_w_index != 5'd0)
                   && (bus.wb_w_index == w_rs2);
   assign w_op1  = w_byp1 ? bus.wb_w_data : bus.rf_data1;
   assign w_op2  = w_byp2 ? bus.wb_w_data : bus.rf_data2;

   // -------------------------------------------------------------------------
   // Load-use hazard against the load currently sitting in ID/EX
   // -------------------------------------------------------------------------
   assign w_load_use = bus.id_valid && r_ex.valid && r_ex.is_load
                       && (r_ex.rd != 5'd0)
                       && ((w_uses_rs1 && (r_ex.rd == w_rs1))
                        || (w_uses_rs2 && (r_ex.rd == w_rs2)));

   // A flush kills the ID instruction, so there is nothing left to hold for.
   assign bus.stall_if = (w_load_use || bus.ex_hold) && !bus.flush;

   // -------------------------------------------------------------------------
   // Next ID/EX contents when the register captures
   // -------------------------------------------------------------------------
   always_comb begin
      w_next           = '0;
      w_next.valid     = bus.id_valid;
      w_next.pc        = bus.id_pc;
      w_next.rs1_data  = w_op1;
      w_next.rs2_data  = w_op2;
      w_next.imm       = w_imm;
      w_next.rs1       = w_rs1;
      w_next.rs2       = w_rs2;
      w_next.rd        = w_rd;
      w_next.opcode    = w_opcode;
      w_next.funct3    = w_funct3;
      w_next.funct7b5  = w_inst[30];
      // Side-effect flags are qualified with valid so an empty slot can never
      // write the register file or trigger a load-use stall downstream.
      w_next.reg_write = bus.id_valid && w_writes_rd && (w_rd != 5'd0);
      w_next.is_load   = bus.id_valid && w_is_load;
   end

   // -------------------------------------------------------------------------
   // ID/EX register. Priority: reset, flush, hold, load-use bubble, capture.
   // Hold beats the bubble: the hazard is simply re-evaluated once EX moves.
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order. Every
      // ID/EX field is reset (it is a handful of flops, not a memory) so the
      // hazard logic never sees X after reset.
      if (rst) begin
         r_ex <= '0;
      end else if (bus.flush) begin
         r_ex <= '0;
      end else if (bus.ex_hold) begin
         r_ex <= r_ex;
      end else if (w_load_use) begin
         r_ex <= '0;
      end else begin
         r_ex <= w_next;
      end
   end

   assign bus.ex_valid     = r_ex.valid;
   assign bus.ex_pc        = r_ex.pc;
   assign bus.ex_rs1_data  = r_ex.rs1_data;
   assign bus.ex_rs2_data  = r_ex.rs2_data;
   assign bus.ex_imm       = r_ex.imm;
   assign bus.ex_rs1       = r_ex.rs1;
   assign bus.ex_rs2       = r_ex.rs2;
   assign bus.ex_rd        = r_ex.rd;
   assign bus.ex_opcode    = r_ex.opcode;
   assign bus.ex_funct3    = r_ex.funct3;
   assign bus.ex_funct7b5  = r_ex.funct7b5;
   assign bus.ex_reg_write = r_ex.reg_write;
   assign bus.ex_is_load   = r_ex.is_load;

endmodule

// File: tb/tb_id_stage.sv
// -----------------------------------------------------------------------------
// tb_id_stage
// Purpose : Self-checking bench for id_stage. A behavioural model of the
//           ID/EX register is advanced on every rising edge and compared with
//           the DUT one time unit later; directed scenarios add hand-computed
//           literal expectations, then randomized traffic runs for a while.
// -----------------------------------------------------------------------------
module tb_id_stage;

   localparam int XLEN      = 32;
   localparam bit BYPASS_EN = 1'b1;

   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] d1;
      logic [31:0] d2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [6:0]  opc;
      logic [2:0]  f3;
      logic        f7b5;
      logic        reg_write;
      logic        is_load;
   } ex_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   id_stage_if #(.XLEN(XLEN)) bus ();

   id_stage #(.XLEN(XLEN), .BYPASS_EN(BYPASS_EN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int  n_cmp = 0;
   int  n_bad = 0;
   ex_t m     = '0;

   task automatic check(input string name, input logic [255:0] got,
                        input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------- model
   function automatic bit uses_rs1(input logic [6:0] op);
      return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
   endfunction

   function automatic bit uses_rs2(input logic [6:0] op);
      return op inside {OP_REG, OP_STORE, OP_BRANCH};
   endfunction

   function automatic bit writes_rd(input logic [6:0] op);
      return op inside {OP_REG, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
   endfunction

   // Immediates built with arithmetic shifts and masks on the whole word.
   function automatic logic [31:0] ref_imm(input logic [31:0] i);
      logic [31:0] s20;
      s20 = 32'($signed(i) >>> 20);
      case (i[6:0])
         OP_LOAD, OP_IMM, OP_JALR: return s20;
         OP_STORE:  return (s20 & ~32'h1F) | 32'(i[11:7]);
         OP_BRANCH: return (32'($signed(i) >>> 19) & 32'hFFFFF000)
                           | (32'(i[7]) << 11) | (32'(i[30:25]) << 5)
                           | (32'(i[11:8]) << 1);
         OP_LUI, OP_AUIPC: return i & 32'hFFFFF000;
         OP_JAL:    return (32'($signed(i) >>> 11) & 32'hFFF00000)
                           | (i & 32'h000FF000) | (32'(i[20]) << 11)
                           | (32'(i[30:21]) << 1);
         default:   return 32'h0;
      endcase
   endfunction

   function automatic logic [31:0] ref_operand(input logic [4:0] idx,
                                               input logic [31:0] rf);
      if (BYPASS_EN && bus.wb_w_en && idx != 0 && idx == bus.wb_w_index)
         return bus.wb_w_data;
      return rf;
   endfunction

   function automatic ex_t ref_capture();
      ex_t e;
      logic [31:0] i;
      i           = bus.id_inst;
      e.valid     = bus.id_valid;
      e.pc        = bus.id_pc;
      e.d1        = ref_operand(i[19:15], bus.rf_data1);
      e.d2        = ref_operand(i[24:20], bus.rf_data2);
      e.imm       = ref_imm(i);
      e.rs1       = i[19:15];
      e.rs2       = i[24:20];
      e.rd        = i[11:7];
      e.opc       = i[6:0];
      e.f3        = i[14:12];
      e.f7b5      = i[30];
      e.reg_write = bus.id_valid && writes_rd(i[6:0]) && i[11:7] != 0;
      e.is_load   = bus.id_valid && i[6:0] == OP_LOAD;
      return e;
   endfunction

   function automatic bit ref_load_use(input ex_t e);
      logic [31:0] i;
      i = bus.id_inst;
      return bus.id_valid && e.valid && e.is_load && e.rd != 0
             && ((uses_rs1(i[6:0]) && e.rd == i[19:15])
              || (uses_rs2(i[6:0]) && e.rd == i[24:20]));
   endfunction

   function automatic ex_t dut_ex();
      ex_t e;
      e.valid     = bus.ex_valid;
      e.pc        = bus.ex_pc;
      e.d1        = bus.ex_rs1_data;
      e.d2        = bus.ex_rs2_data;
      e.imm       = bus.ex_imm;
      e.rs1       = bus.ex_rs1;
      e.rs2       = bus.ex_rs2;
      e.rd        = bus.ex_rd;
      e.opc       = bus.ex_opcode;
      e.f3        = bus.ex_funct3;
      e.f7b5      = bus.ex_funct7b5;
      e.reg_write = bus.ex_reg_write;
      e.is_load   = bus.ex_is_load;
      return e;
   endfunction

   // Compare process: inputs only change on the falling edge, so at the
   // rising edge they are the values the DUT samples.
   always @(posedge clk) begin
      if (rst || bus.flush)       m = '0;
      else if (bus.ex_hold)       m = m;
      else if (ref_load_use(m))   m = '0;
      else                        m = ref_capture();
      #1;
      check("ex_regs", 256'(dut_ex()), 256'(m));
      check("stall_if", 256'(bus.stall_if),
            256'((ref_load_use(m) || bus.ex_hold) && !bus.flush));
      check("rs_index", 256'({bus.rs1_index, bus.rs2_index}),
            256'({bus.id_inst[19:15], bus.id_inst[24:20]}));
   end

   // ---------------------------------------------------------------- stimulus
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic set_inst(input logic [31:0] inst);
      bus.id_inst  = inst;
      bus.id_pc    = bus.id_pc + 32'd4;
      bus.id_valid = 1'b1;
   endtask

   function automatic logic [31:0] rand_inst();
      logic [31:0] i;
      i = $urandom;
      case ($urandom_range(0, 10))
         0:       i[6:0] = OP_LUI;
         1:       i[6:0] = OP_AUIPC;
         2:       i[6:0] = OP_JAL;
         3:       i[6:0] = OP_JALR;
         4:       i[6:0] = OP_BRANCH;
         5, 6:    i[6:0] = OP_LOAD;
         7:       i[6:0] = OP_STORE;
         8:       i[6:0] = OP_IMM;
         9:       i[6:0] = OP_REG;
         default: i[6:0] = 7'b0001111;
      endcase
      i[11:7]  = 5'($urandom_range(0, 7));
      i[19:15] = 5'($urandom_range(0, 7));
      i[24:20] = 5'($urandom_range(0, 7));
      return i;
   endfunction

   logic [31:0] imm_inst [4];
   logic [31:0] imm_exp  [4];
   bit          keep;

   initial begin
      rst            = 1'b1;
      bus.id_valid   = 1'b0;
      bus.id_inst    = 32'h0;
      bus.id_pc      = 32'h100;
      bus.rf_data1   = 32'h0;
      bus.rf_data2   = 32'h0;
      bus.wb_w_en    = 1'b0;
      bus.wb_w_index = 5'd0;
      bus.wb_w_data  = 32'h0;
      bus.flush      = 1'b0;
      bus.ex_hold    = 1'b0;

      // 1. Reset with a valid instruction present, then ADDI x5,x0,7
      set_inst(32'h00700293);
      tick();
      tick();
      check("rst_valid", 256'(bus.ex_valid), 256'(1'b0));
      check("rst_imm", 256'(bus.ex_imm), 256'(32'h0));
      check("rst_stall", 256'(bus.stall_if), 256'(1'b0));
      @(negedge clk) rst = 1'b0;
      tick();
      check("addi_valid", 256'(bus.ex_valid), 256'(1'b1));
      check("addi_rd", 256'(bus.ex_rd), 256'(5'd5));
      check("addi_imm", 256'(bus.ex_imm), 256'(32'd7));
      check("addi_wr", 256'(bus.ex_reg_write), 256'(1'b1));

      // 2. WB bypass into rs1, then index 0 is never bypassed
      @(negedge clk);
      set_inst(32'h00218233);             // ADD x4,x3,x2
      bus.rf_data1   = 32'h11;
      bus.rf_data2   = 32'h22;
      bus.wb_w_en    = 1'b1;
      bus.wb_w_index = 5'd3;
      bus.wb_w_data  = 32'hAB;
      tick();
      check("byp_rs1", 256'(bus.ex_rs1_data), 256'(32'hAB));
      check("byp_rs2", 256'(bus.ex_rs2_data), 256'(32'h22));
      @(negedge clk);
      set_inst(32'h00200233);             // ADD x4,x0,x2
      bus.wb_w_index = 5'd0;
      tick();
      check("byp_x0", 256'(bus.ex_rs1_data), 256'(32'h11));
      @(negedge clk) bus.wb_w_en = 1'b0;

      // 3. Load-use: one bubble, then the dependent ADD is captured
      set_inst(32'h0000A303);             // LW x6,0(x1)
      tick();
      check("lw_is_load", 256'(bus.ex_is_load), 256'(1'b1));
      @(negedge clk);
      set_inst(32'h002303B3);             // ADD x7,x6,x2
      #1 check("lu_stall", 256'(bus.stall_if), 256'(1'b1));
      tick();
      check("lu_bubble", 256'(bus.ex_valid), 256'(1'b0));
      check("lu_stall_drop", 256'(bus.stall_if), 256'(1'b0));
      tick();
      check("lu_add_valid", 256'(bus.ex_valid), 256'(1'b1));
      check("lu_add_rd", 256'(bus.ex_rd), 256'(5'd7));
      @(negedge clk);
      set_inst(32'h0000A003);             // LW x0,0(x1)
      tick();
      @(negedge clk);
      set_inst(32'h002003B3);             // ADD x7,x0,x2
      #1 check("lw_x0_nostall", 256'(bus.stall_if), 256'(1'b0));
      tick();
      check("lw_x0_next", 256'(bus.ex_valid), 256'(1'b1));

      // 4. Immediate formats
      imm_inst[0] = 32'hFE20AE23; imm_exp[0] = 32'hFFFFFFFC; // SW x2,-4(x1)
      imm_inst[1] = 32'hFE208CE3; imm_exp[1] = 32'hFFFFFFF8; // BEQ -8
      imm_inst[2] = 32'h123450B7; imm_exp[2] = 32'h12345000; // LUI 0x12345
      imm_inst[3] = 32'h001000EF; imm_exp[3] = 32'h00000800; // JAL +2048
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         set_inst(imm_inst[k]);
         tick();
         check($sformatf("imm_%0d", k), 256'(bus.ex_imm), 256'(imm_exp[k]));
         check($sformatf("imm_model_%0d", k), 256'(m.imm), 256'(imm_exp[k]));
      end

      // 5. Hold freezes the register; flush beats hold
      @(negedge clk);
      set_inst(32'h00700293);
      tick();
      @(negedge clk);
      set_inst(32'h002303B3);
      bus.ex_hold = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 check("hold_stall", 256'(bus.stall_if), 256'(1'b1));
         tick();
         check("hold_imm", 256'(bus.ex_imm), 256'(32'd7));
         check("hold_rd", 256'(bus.ex_rd), 256'(5'd5));
         @(negedge clk);
      end
      bus.flush = 1'b1;
      #1 check("flush_stall", 256'(bus.stall_if), 256'(1'b0));
      tick();
      check("flush_valid", 256'(bus.ex_valid), 256'(1'b0));
      @(negedge clk);
      bus.flush   = 1'b0;
      bus.ex_hold = 1'b0;

      // 6. Reset arriving during a load-use stall
      set_inst(32'h0000A303);
      tick();
      @(negedge clk);
      set_inst(32'h002303B3);
      #1 check("rstlu_stall", 256'(bus.stall_if), 256'(1'b1));
      rst = 1'b1;
      tick();
      check("rstlu_valid", 256'(bus.ex_valid), 256'(1'b0));
      check("rstlu_drop", 256'(bus.stall_if), 256'(1'b0));
      @(negedge clk) rst = 1'b0;
      #1 check("rstlu_after", 256'(bus.stall_if), 256'(1'b0));
      tick();
      check("rstlu_cap", 256'(bus.ex_valid), 256'(1'b1));

      // Randomized traffic; IF/ID is held whenever stall_if was high at the edge
      keep = 1'b0;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         if (!keep) begin
            bus.id_inst  = rand_inst();
            bus.id_pc    = $urandom & 32'hFFFFFFFC;
            bus.id_valid = ($urandom_range(0, 9) != 0);
         end
         bus.rf_data1   = $urandom;
         bus.rf_data2   = $urandom;
         bus.wb_w_en    = ($urandom_range(0, 1) == 1);
         bus.wb_w_index = 5'($urandom_range(0, 7));
         bus.wb_w_data  = $urandom;
         bus.flush      = ($urandom_range(0, 11) == 0);
         bus.ex_hold    = ($urandom_range(0, 6) == 0);
         rst            = ($urandom_range(0, 49) == 0);
         #1 keep = bus.stall_if && !rst;
      end
      @(negedge clk);
      rst         = 1'b0;
      bus.flush   = 1'b0;
      bus.ex_hold = 1'b0;
      tick();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- RV32I decode stage: sits between the IF/ID register and EX.
- Drives register-file read indices and consumes the register file's combinational read data.
- Bypasses same-cycle writeback data, since a register-file write is not visible until the next edge.
- Detects load-use hazards, generates immediates and holds the ID/EX pipeline register with bubble/flush/hold control.

Parameters:
XLEN, 32, datapath width (only 32 supported)
BYPASS_EN, 1, 1 = WB-to-ID bypass enabled; 0 = raw register-file data

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
id_valid  input  1  IF/ID holds a valid instruction
id_inst  input  32  instruction word from IF/ID
id_pc  input  32  PC of id_inst
rs1_index  output  5  register-file read index 1 (id_inst[19:15])
rs2_index  output  5  register-file read index 2 (id_inst[24:20])
rf_data1  input  32  register-file read data 1
rf_data2  input  32  register-file read data 2
wb_w_en  input  1  WB write enable (same signal fed to register file)
wb_w_index  input  5  WB destination index
wb_w_data  input  32  WB write data
flush  input  1  branch/jump redirect from EX; kill ID instruction
ex_hold  input  1  downstream (MEM) stall; freeze ID/EX register
stall_if  output  1  hold PC and IF/ID this cycle (combinational)
ex_valid  output  1  ID/EX entry valid
ex_pc  output  32  registered PC
ex_rs1_data  output  32  registered operand 1 after bypass
ex_rs2_data  output  32  registered operand 2 after bypass
ex_imm  output  32  registered sign-extended immediate
ex_rs1  output  5  registered rs1 index (for EX forwarding)
ex_rs2  output  5  registered rs2 index
ex_rd  output  5  registered rd (id_inst[11:7])
ex_opcode  output  7  registered opcode
ex_funct3  output  3  registered funct3
ex_funct7b5  output  1  registered id_inst[30]
ex_reg_write  output  1  instruction writes rd and rd != 0
ex_is_load  output  1  opcode == 0000011

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Read indices: rs1_index and rs2_index are combinational slices of id_inst, whatever the value of id_valid.
- Operand use:
  - uses_rs1 = opcode not in {LUI 0110111, AUIPC 0010111, JAL 1101111}.
  - uses_rs2 = opcode in {R 0110011, S 0100011, B 1100011}.
- Register write: writes_rd = opcode in {R, I-ALU 0010011, LOAD, JAL, JALR 1100111, LUI, AUIPC}. ex_reg_write captures writes_rd && rd != 0.
- Unknown opcode: captured with ex_reg_write=0, ex_is_load=0, imm=0.
- Immediate by opcode:
  - I (LOAD, I-ALU, JALR): sext inst[31:20].
  - S: sext {inst[31:25], inst[11:7]}.
  - B: sext {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U: {inst[31:12], 12'b0}.
  - J: sext {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R: 0.
- Bypass (BYPASS_EN=1):
  - op1 = wb_w_data if wb_w_en && wb_w_index != 0 && wb_w_index == rs1_index, else rf_data1. op2 uses the same rule.
  - Index 0 is never bypassed.
- Load-use hazard, combinational:
  - load_use = id_valid && ex_valid && ex_is_load && ex_rd != 0 && ((uses_rs1 && ex_rd == rs1_index) || (uses_rs2 && ex_rd == rs2_index)).
  - stall_if = (load_use || ex_hold) && !flush.
- ID/EX register update on rising clk, first match wins:
  1. rst: every ex_* output <= 0.
  2. flush: every ex_* output <= 0 (bubble).
  3. ex_hold: all ex_* outputs keep their value.
  4. load_use: bubble, every ex_* output <= 0. IF/ID is held by stall_if, so the instruction re-decodes next cycle.
  5. Otherwise: capture all fields. ex_valid <= id_valid. If !id_valid, ex_reg_write and ex_is_load <= 0.
- Reset values: every ex_* output is 0. stall_if depends only on inputs and ex_* outputs (0 after reset).
- Latency: one cycle from IF/ID to ID/EX. A load-use hazard costs exactly one bubble.
- Simultaneous events:
  - flush together with load_use or ex_hold: flush wins, ex_valid <= 0 and stall_if = 0.
  - ex_hold together with load_use: hold wins (no bubble inserted); the hazard is re-evaluated after hold releases.
- Reset mid-stall: the register clears and ex_valid=0, so stall_if drops in the cycle after reset.

Test Plan:
1. Reset: rst=1 for 2 cycles with id_valid=1 -> all ex_* = 0, stall_if=0. After release, ADDI x5,x0,7 (0x00700293) -> next cycle ex_valid=1, ex_rd=5, ex_imm=7, ex_reg_write=1.
2. WB bypass: rf_data1=0x11, wb_w_en=1, wb_w_index=3, wb_w_data=0xAB, ADD x4,x3,x2 -> ex_rs1_data=0xAB. Repeat with wb_w_index=0 and rs1=0 -> ex_rs1_data=rf_data1.
3. Load-use: LW x6,0(x1) captured, then ADD x7,x6,x2 in ID -> stall_if=1 for one cycle, one bubble (ex_valid=0). ADD captured the following cycle. LW into x0 -> no stall.
4. Immediates: SW imm=-4 -> ex_imm=0xFFFFFFFC. BEQ offset -8 -> 0xFFFFFFF8. LUI 0x12345 -> 0x12345000. JAL +2048 -> 0x00000800.
5. Hold vs flush: ex_hold=1 for 3 cycles -> ex_* unchanged, stall_if=1. Assert flush together with ex_hold -> ex_valid=0, stall_if=0.
6. Reset during load-use stall -> ex_valid=0 next cycle, stall_if=0 thereafter.
